// File: rtl/udp_vlg_tx.sv
`timescale 1ns/1ps
// udp_vlg_tx -- UDP transmit framer.
//
// Takes one datagram request (source/destination port, payload length) and a
// byte-wide payload stream. It emits the 8-byte UDP header followed by the
// payload as one framed byte stream. All header fields are big-endian. The
// checksum is sent as 0x0000, which means "not computed".
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   meta_val             one-cycle request, sampled only while busy=0
//   meta_src_port        UDP source port
//   meta_dst_port        UDP destination port
//   meta_pld_len         payload length in bytes
//   busy                 high from request accept until the frame is finished
//   pld_dat/val/eof/rdy  payload input stream (valid/ready handshake)
//   out_dat/val/sof/eof  framed output stream, registered
//   out_rdy              downstream accept
//   udp_len              latched payload length + 8, valid while busy
//   err_len              one-cycle pulse on a length error (MTU reject,
//                        short source or long source)
module udp_vlg_tx #(
  parameter int unsigned MTU = 1472
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        meta_val,
  input  logic [15:0] meta_src_port,
  input  logic [15:0] meta_dst_port,
  input  logic [15:0] meta_pld_len,
  output logic        busy,
  input  logic [7:0]  pld_dat,
  input  logic        pld_val,
  input  logic        pld_eof,
  output logic        pld_rdy,
  output logic [7:0]  out_dat,
  output logic        out_val,
  output logic        out_sof,
  output logic        out_eof,
  input  logic        out_rdy,
  output logic [15:0] udp_len,
  output logic        err_len
);

  // Keeps the 16-bit udp_len add (payload + 8) from overflowing.
  if (MTU > 65527) begin : g_mtu_chk
    $error("udp_vlg_tx: MTU must not exceed 65527");
  end

  localparam logic [15:0] MTU_W = 16'(MTU);

  typedef enum logic [1:0] {IDLE, HDR, PLD, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [15:0] src_q, src_d;
  logic [15:0] dst_q, dst_d;
  logic [15:0] pld_len_q, pld_len_d;
  logic [15:0] udp_len_q, udp_len_d;
  logic [2:0]  hcnt_q, hcnt_d;
  logic [15:0] pcnt_q, pcnt_d;
  // The byte marked out_eof is already in the output register. The frame is
  // waiting for that byte to transfer.
  logic        last_q, last_d;
  // DRAIN has consumed the source's pld_eof byte. It may still be waiting for
  // the out_eof byte to transfer.
  logic        drain_done_q, drain_done_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic [7:0]  out_dat_q, out_dat_d;
  logic        out_val_q, out_val_d;
  logic        out_sof_q, out_sof_d;
  logic        out_eof_q, out_eof_d;

  logic        ld;        // the output register can take a new byte
  logic        xfer_last; // the out_eof byte transfers this cycle
  logic [15:0] pcnt_inc;
  logic [7:0]  hdr_byte;
  logic        drain_acc;

  assign ld        = !out_val_q || out_rdy;
  assign xfer_last = out_val_q && out_rdy && out_eof_q;
  assign pcnt_inc  = pcnt_q + 16'd1;
  assign drain_acc = pld_val && !drain_done_q;

  always_comb begin
    hdr_byte = 8'h00;
    case (hcnt_q)
      3'd0:    hdr_byte = src_q[15:8];
      3'd1:    hdr_byte = src_q[7:0];
      3'd2:    hdr_byte = dst_q[15:8];
      3'd3:    hdr_byte = dst_q[7:0];
      3'd4:    hdr_byte = udp_len_q[15:8];
      3'd5:    hdr_byte = udp_len_q[7:0];
      default: hdr_byte = 8'h00; // checksum: not computed
    endcase
  end

  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    pld_len_d    = pld_len_q;
    udp_len_d    = udp_len_q;
    hcnt_d       = hcnt_q;
    pcnt_d       = pcnt_q;
    last_d       = last_q;
    drain_done_d = drain_done_q;
    busy_d       = busy_q;
    err_d        = 1'b0;
    out_dat_d    = out_dat_q;
    out_val_d    = out_val_q;
    out_sof_d    = out_sof_q;
    out_eof_d    = out_eof_q;
    pld_rdy      = 1'b0;

    // Empty the output register once its byte has been taken. A load below
    // overrides this.
    if (ld) begin
      out_val_d = 1'b0;
      out_sof_d = 1'b0;
      out_eof_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (meta_val) begin
          if (meta_pld_len <= MTU_W) begin
            src_d        = meta_src_port;
            dst_d        = meta_dst_port;
            pld_len_d    = meta_pld_len;
            udp_len_d    = meta_pld_len + 16'd8;
            hcnt_d       = 3'd0;
            pcnt_d       = 16'd0;
            last_d       = 1'b0;
            drain_done_d = 1'b0;
            busy_d       = 1'b1;
            state_d      = HDR;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      HDR: begin
        if (last_q) begin
          // This path is taken only for a zero-length payload.
          if (xfer_last) begin
            last_d  = 1'b0;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end else if (ld) begin
          out_val_d = 1'b1;
          out_dat_d = hdr_byte;
          out_sof_d = (hcnt_q == 3'd0);
          hcnt_d    = hcnt_q + 3'd1;
          if (hcnt_q == 3'd7) begin
            if (pld_len_q == 16'd0) begin
              out_eof_d = 1'b1;
              last_d    = 1'b1;
            end else begin
              state_d = PLD;
            end
          end
        end
      end

      PLD: begin
        if (last_q) begin
          if (xfer_last) begin
            last_d  = 1'b0;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end else begin
          pld_rdy = ld;
          if (pld_val && ld) begin
            out_val_d = 1'b1;
            out_dat_d = pld_dat;
            pcnt_d    = pcnt_inc;
            if (pcnt_inc == pld_len_q) begin
              out_eof_d = 1'b1;
              if (pld_eof) begin
                last_d = 1'b1;
              end else begin
                // Long source: the rest of its bytes are dropped in DRAIN.
                err_d   = 1'b1;
                state_d = DRAIN;
              end
            end else if (pld_eof) begin
              // Short source: end the frame early. No padding is added.
              out_eof_d = 1'b1;
              err_d     = 1'b1;
              last_d    = 1'b1;
            end
          end
        end
      end

      DRAIN: begin
        pld_rdy = !drain_done_q;
        if (drain_acc && pld_eof) begin
          drain_done_d = 1'b1;
        end
        // Finish only when the source has ended and the out_eof byte is gone
        // (or is leaving this cycle).
        if ((drain_done_q || (drain_acc && pld_eof)) && ld) begin
          drain_done_d = 1'b0;
          busy_d       = 1'b0;
          state_d      = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      src_q        <= 16'd0;
      dst_q        <= 16'd0;
      pld_len_q    <= 16'd0;
      udp_len_q    <= 16'd0;
      hcnt_q       <= 3'd0;
      pcnt_q       <= 16'd0;
      last_q       <= 1'b0;
      drain_done_q <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      out_dat_q    <= 8'd0;
      out_val_q    <= 1'b0;
      out_sof_q    <= 1'b0;
      out_eof_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      pld_len_q    <= pld_len_d;
      udp_len_q    <= udp_len_d;
      hcnt_q       <= hcnt_d;
      pcnt_q       <= pcnt_d;
      last_q       <= last_d;
      drain_done_q <= drain_done_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      out_dat_q    <= out_dat_d;
      out_val_q    <= out_val_d;
      out_sof_q    <= out_sof_d;
      out_eof_q    <= out_eof_d;
    end
  end

  assign busy    = busy_q;
  assign err_len = err_q;
  assign out_dat = out_dat_q;
  assign out_val = out_val_q;
  assign out_sof = out_sof_q;
  assign out_eof = out_eof_q;
  assign udp_len = udp_len_q;

endmodule

// File: tb/tb_udp_vlg_tx.sv
`timescale 1ns/1ps
// Directed testbench for udp_vlg_tx. It captures every output transfer and
// compares the captured frames with hand-computed byte sequences.
module tb_udp_vlg_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        meta_val = 1'b0;
  logic [15:0] meta_src_port = 16'd0;
  logic [15:0] meta_dst_port = 16'd0;
  logic [15:0] meta_pld_len = 16'd0;
  logic        busy;
  logic [7:0]  pld_dat = 8'd0;
  logic        pld_val = 1'b0;
  logic        pld_eof = 1'b0;
  logic        pld_rdy;
  logic [7:0]  out_dat;
  logic        out_val;
  logic        out_sof;
  logic        out_eof;
  logic        out_rdy = 1'b1;
  logic [15:0] udp_len;
  logic        err_len;

  udp_vlg_tx #(.MTU(1472)) dut (
    .clk(clk), .rst_n(rst_n),
    .meta_val(meta_val), .meta_src_port(meta_src_port),
    .meta_dst_port(meta_dst_port), .meta_pld_len(meta_pld_len),
    .busy(busy),
    .pld_dat(pld_dat), .pld_val(pld_val), .pld_eof(pld_eof), .pld_rdy(pld_rdy),
    .out_dat(out_dat), .out_val(out_val), .out_sof(out_sof), .out_eof(out_eof),
    .out_rdy(out_rdy), .udp_len(udp_len), .err_len(err_len)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: capture transfers and count events, sampled on the falling edge.
  logic [7:0] cap_dat[$];
  logic       cap_sof[$];
  logic       cap_eof[$];
  int         err_cnt, oval_cnt, prdy_cnt, busy_cnt;
  logic       stall_prev = 1'b0;
  logic [7:0] prev_dat = 8'd0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_val && out_rdy) begin
        cap_dat.push_back(out_dat);
        cap_sof.push_back(out_sof);
        cap_eof.push_back(out_eof);
      end
      if (err_len) err_cnt++;
      if (out_val) oval_cnt++;
      if (pld_rdy) prdy_cnt++;
      if (busy)    busy_cnt++;
      if (stall_prev) begin
        check("hold_val", 32'(out_val), 32'd1);
        check("hold_dat", 32'(out_dat), 32'(prev_dat));
      end
      if (out_val && !out_rdy) check("pld_rdy_stall", 32'(pld_rdy), 32'd0);
      stall_prev = out_val && !out_rdy;
      prev_dat   = out_dat;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // When backpressure mode is on, toggle out_rdy every cycle.
  logic bp_mode = 1'b0;
  initial begin
    forever begin
      @(posedge clk); #1;
      if (bp_mode) out_rdy = ~out_rdy;
    end
  end

  logic [7:0] exp_q[$];
  logic [7:0] src_q[$];

  task automatic clear_mon();
    cap_dat.delete(); cap_sof.delete(); cap_eof.delete();
    err_cnt = 0; oval_cnt = 0; prdy_cnt = 0; busy_cnt = 0;
  endtask

  task automatic start_req(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l);
    @(posedge clk); #1;
    meta_src_port = s; meta_dst_port = d; meta_pld_len = l; meta_val = 1'b1;
    @(posedge clk); #1;
    meta_val = 1'b0;
  endtask

  task automatic send_src();
    logic acc;
    for (int i = 0; i < src_q.size(); i++) begin
      pld_dat = src_q[i];
      pld_eof = (i == src_q.size() - 1);
      pld_val = 1'b1;
      acc = 1'b0;
      for (int t = 0; t < 100 && !acc; t++) begin
        @(negedge clk);
        acc = pld_rdy;
        @(posedge clk); #1;
      end
      check("src_accept", 32'(acc), 32'd1);
      if (!acc) break;
    end
    pld_val = 1'b0;
    pld_eof = 1'b0;
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 300 && busy; t++) begin
      @(posedge clk); #1;
    end
    check("idle_reached", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic compare_frame(input string name);
    check({name, "_nbytes"}, 32'(cap_dat.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < cap_dat.size(); i++) begin
      check({name, "_dat"}, 32'(cap_dat[i]), 32'(exp_q[i]));
      check({name, "_sof"}, 32'(cap_sof[i]), 32'(i == 0));
      check({name, "_eof"}, 32'(cap_eof[i]), 32'(i == exp_q.size() - 1));
    end
    $display("[TB] frame %s: %0d bytes captured, %0d err pulses", name, cap_dat.size(), err_cnt);
  endtask

  initial begin
    clear_mon();
    // Reset state.
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out", {26'd0, out_val, out_sof, out_eof, pld_rdy, err_len, 1'b0}, 32'd0);
    check("rst_dat_len", {8'd0, out_dat, udp_len}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic frame.
    clear_mon();
    src_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    exp_q = '{8'h12, 8'h34, 8'h00, 8'h50, 8'h00, 8'h0C, 8'h00, 8'h00,
              8'hDE, 8'hAD, 8'hBE, 8'hEF};
    start_req(16'h1234, 16'h0050, 16'd4);
    check("basic_busy", 32'(busy), 32'd1);
    check("basic_udp_len", 32'(udp_len), 32'd12);
    send_src();
    wait_idle();
    compare_frame("basic");
    check("basic_busy_cycles", 32'(busy_cnt), 32'd13);
    check("basic_err", 32'(err_cnt), 32'd0);

    // Zero-length payload.
    clear_mon();
    exp_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00, 8'h08, 8'h00, 8'h00};
    start_req(16'hAABB, 16'hCCDD, 16'd0);
    wait_idle();
    compare_frame("zero");
    check("zero_pld_rdy", 32'(prdy_cnt), 32'd0);

    // Backpressure.
    clear_mon();
    src_q = '{8'h01, 8'h02, 8'h03};
    exp_q = '{8'hAB, 8'hCD, 8'h11, 8'h11, 8'h00, 8'h0B, 8'h00, 8'h00,
              8'h01, 8'h02, 8'h03};
    bp_mode = 1'b1;
    start_req(16'hABCD, 16'h1111, 16'd3);
    send_src();
    wait_idle();
    bp_mode = 1'b0;
    out_rdy = 1'b1;
    compare_frame("backpressure");

    // MTU reject, then the largest accepted length.
    clear_mon();
    start_req(16'h0001, 16'h0002, 16'd1473);
    repeat (5) @(posedge clk);
    #1;
    check("mtu_err_pulses", 32'(err_cnt), 32'd1);
    check("mtu_busy_cycles", 32'(busy_cnt), 32'd0);
    check("mtu_out_val_cycles", 32'(oval_cnt), 32'd0);
    $display("[TB] request len=1473 rejected, err pulses %0d", err_cnt);
    start_req(16'h0001, 16'h0002, 16'd1472);
    check("mtu_max_busy", 32'(busy), 32'd1);
    check("mtu_max_udp_len", 32'(udp_len), 32'h05C8);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Short source.
    clear_mon();
    src_q = '{8'hA1, 8'hA2, 8'hA3};
    exp_q = '{8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h0D, 8'h00, 8'h00,
              8'hA1, 8'hA2, 8'hA3};
    start_req(16'h0001, 16'h0002, 16'd5);
    send_src();
    wait_idle();
    compare_frame("short");
    check("short_err", 32'(err_cnt), 32'd1);

    // Long source.
    clear_mon();
    src_q = '{8'hB1, 8'hB2, 8'hB3, 8'hB4};
    exp_q = '{8'h00, 8'h03, 8'h00, 8'h04, 8'h00, 8'h0A, 8'h00, 8'h00,
              8'hB1, 8'hB2};
    start_req(16'h0003, 16'h0004, 16'd2);
    send_src();
    wait_idle();
    compare_frame("long");
    check("long_err", 32'(err_cnt), 32'd1);

    // Reset during payload byte 2.
    clear_mon();
    start_req(16'h5555, 16'h6666, 16'd10);
    pld_dat = 8'h55; pld_eof = 1'b0; pld_val = 1'b1;
    for (int t = 0; t < 100 && cap_dat.size() < 9; t++) begin
      @(negedge clk); #1;
    end
    check("rst_mid_reached", 32'(cap_dat.size()), 32'd9);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_out", {26'd0, out_val, out_sof, out_eof, pld_rdy, err_len, 1'b0}, 32'd0);
    check("rst_mid_dat_len", {8'd0, out_dat, udp_len}, 32'd0);
    $display("[TB] reset mid-payload applied after %0d bytes", cap_dat.size());
    pld_val = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    clear_mon();
    src_q = '{8'h77};
    exp_q = '{8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h00, 8'h09, 8'h00, 8'h00, 8'h77};
    start_req(16'h0A0B, 16'h0C0D, 16'd1);
    send_src();
    wait_idle();
    compare_frame("post_reset");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected done");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/udp_vlg_tx.md
Name: udp_vlg_tx

Overview:
UDP transmit framer: accepts one datagram's metadata (ports, payload length) plus a byte-wide payload stream, and emits the 8-byte UDP header followed by the payload as a single framed byte stream toward the IPv4 transmitter. It is the transmit-side counterpart of the UDP receive parser and uses the same udp_hdr_t field layout: src_port, dst_port, length, cks, all 16 bit and big-endian on the wire. The UDP checksum is transmitted as 0x0000, i.e. "not computed", which is legal for UDP over IPv4.

Parameters:
MTU, 1472, maximum accepted payload length in bytes; larger requests are rejected.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
meta_val  in  1  single-cycle datagram request; sampled only when busy=0
meta_src_port  in  16  UDP source port
meta_dst_port  in  16  UDP destination port
meta_pld_len  in  16  payload length in bytes
busy  out  1  high from accepted request until the last byte transfers
pld_dat  in  8  payload byte
pld_val  in  1  payload byte valid
pld_eof  in  1  marks the last payload byte from the source
pld_rdy  out  1  payload byte accepted when pld_val&&pld_rdy
out_dat  out  8  framed UDP byte
out_val  out  1  output byte valid
out_sof  out  1  first header byte
out_eof  out  1  last byte of datagram
out_rdy  in  1  downstream accept; a transfer occurs when out_val&&out_rdy
udp_len  out  16  latched UDP length = meta_pld_len+8; valid while busy
err_len  out  1  one-cycle pulse on a length error

Behaviour:
- Reset values: all outputs 0 (busy, pld_rdy, out_*, udp_len, err_len); FSM state = IDLE.
- Output register: out_dat, out_val, out_sof and out_eof are registered. The register loads when empty or being consumed (!out_val || out_rdy). It holds all values stable while out_val && !out_rdy.
- FSM states: IDLE, HDR, PLD, DRAIN.
- IDLE, request accept:
  - If meta_val && meta_pld_len<=MTU: latch ports, set udp_len=meta_pld_len+8, busy=1, byte counter=0, go to HDR.
  - The first header byte appears on out_val in the next cycle, giving 1-cycle latency.
- IDLE, request reject: if meta_pld_len>MTU, pulse err_len for one cycle, stay in IDLE, emit nothing.
- HDR:
  - Emit 8 bytes in order: src_port[15:8], src_port[7:0], dst_port[15:8], dst_port[7:0], udp_len[15:8], udp_len[7:0], 0x00, 0x00.
  - out_sof=1 on byte 0 only.
  - The counter advances on each load.
  - After byte 7 loads: go to PLD if length>0. If length==0, out_eof=1 on byte 7 and return to IDLE once it transfers.
- PLD:
  - pld_rdy = (!out_val || out_rdy), combinationally, and only in this state.
  - Each accepted pld byte loads the output register and increments the payload counter.
  - out_eof=1 on the byte where the counter reaches meta_pld_len, or where pld_eof=1, whichever happens first.
- Short source (pld_eof before the count is reached): the byte carries out_eof, err_len pulses in the same cycle as the load, and the FSM returns to IDLE after the transfer. No padding is added.
- Long source (count reached with pld_eof=0): out_eof on byte meta_pld_len, err_len pulses, go to DRAIN.
- DRAIN: pld_rdy=1; bytes are discarded without output until a byte with pld_eof=1 is accepted, then go to IDLE; busy stays 1 throughout.
- Completion: busy drops in the cycle after the out_eof byte transfers (or after DRAIN ends, whichever is later). A new meta_val is accepted the same cycle busy is 0.
- meta_val while busy=1 is ignored; there is no queueing.
- Arithmetic: the 16-bit add for udp_len cannot overflow, because MTU<=65527 is required and checked by a synthesis-time assertion.
- Async reset mid-frame: immediately clears all state and outputs; the partial frame is abandoned, and downstream sees out_val drop.

Test Plan:
- Basic: src=0x1234, dst=0x0050, len=4, payload DE AD BE EF, out_rdy=1 → out bytes 12 34 00 50 00 0C 00 00 DE AD BE EF; sof on byte 0, eof on EF; udp_len=12; busy low after 13 cycles.
- Zero payload: len=0 → exactly 8 header bytes, eof on the 8th byte (0x00), pld_rdy never asserts, length field 00 08.
- Backpressure: len=3, out_rdy toggles 1/0 every cycle → out_dat/out_val stable while stalled, pld_rdy=0 whenever out_val&&!out_rdy, correct 11-byte sequence.
- MTU reject: len=1473 → err_len single pulse, busy stays 0, no out_val.
- Short source: len=5, source sends 3 bytes with pld_eof on the 3rd → eof on the 3rd payload byte, err_len pulse, 11 bytes total; long source: len=2, source sends 4 bytes → eof on the 2nd payload byte, bytes 3-4 consumed silently, err_len pulse.
- Reset mid-payload: assert rst_n=0 during payload byte 2 of len=10 → all outputs 0 immediately; a new request after release produces a clean frame with sof.
